// File: rtl/video_system_leds_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The CPU side drives address/strobes/data; the PIO returns registered readdata.
interface video_system_leds_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/video_system_leds.sv
// LED output PIO: data register with atomic set/clear writes and a blink
// engine that toggles a masked subset of LEDs every blink_period+1 cycles.
// Reads are registered and address-muxed like the other PIO slaves.
module video_system_leds #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          PERIOD_WIDTH = 24,
  parameter logic [31:0] RESET_VALUE  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  video_system_leds_if.slave    bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0]   data_q,     data_d;
  logic [DATA_WIDTH-1:0]   mask_q,     mask_d;
  logic [PERIOD_WIDTH-1:0] period_q,   period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q,      cnt_d;
  logic                    phase_q,    phase_d;
  logic [31:0]             readdata_q, readdata_d;

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [PERIOD_WIDTH-1:0] wr_period;
  logic                    unused_wdata;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_data   = bus.writedata[DATA_WIDTH-1:0];
  assign wr_period = bus.writedata[PERIOD_WIDTH-1:0];
  // Bits of writedata above the widest register are intentionally dropped.
  assign unused_wdata = ^bus.writedata;

  // Data/mask/period register updates; only one register can be addressed per write.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:     data_d   = wr_data;
        ADDR_MASK:     mask_d   = wr_data;
        ADDR_PERIOD:   period_d = wr_period;
        ADDR_OUTSET:   data_d   = data_q | wr_data;
        ADDR_OUTCLEAR: data_d   = data_q & ~wr_data;
        default:       ;
      endcase
    end
  end

  // Blink engine: a period write restarts the cycle in the lit phase and wins
  // over a wrap on the same edge; period 0 parks the engine lit.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (bus.address == ADDR_PERIOD)) begin
      cnt_d   = wr_period;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - PERIOD_WIDTH'(1);
    end else begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end
  end

  // Read mux samples pre-edge state, so a same-cycle write reads back the old value.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:   readdata_d[DATA_WIDTH-1:0]   = data_q;
      ADDR_MASK:   readdata_d[DATA_WIDTH-1:0]   = mask_q;
      ADDR_PERIOD: readdata_d[PERIOD_WIDTH-1:0] = period_q;
      ADDR_STATUS: begin
        readdata_d[PERIOD_WIDTH-1:0] = cnt_q;
        readdata_d[31]               = phase_q;
      end
      default:     readdata_d = '0;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= DATA_RST;
      mask_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  // Masked LEDs are dark while phase is 0; everything else follows data.
  assign out_port = data_q & ~(mask_q & {DATA_WIDTH{~phase_q}});

endmodule
